// File: rtl/accelerator_convolutional_fnn_sequencer_if.sv
// Host, memory and core-side signal bundle for the convolutional FNN sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface accelerator_convolutional_fnn_sequencer_if #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned ADDR_SIZE = 32
);
  logic                 SEQ_START;
  logic                 SEQ_BUSY;
  logic                 SEQ_READY;
  logic                 SEQ_ERROR;
  logic [DATA_SIZE-1:0] SIZE_X_IN;
  logic [DATA_SIZE-1:0] SIZE_L_IN;
  logic [ADDR_SIZE-1:0] W_BASE;
  logic [ADDR_SIZE-1:0] B_BASE;
  logic [ADDR_SIZE-1:0] X_BASE;
  logic [ADDR_SIZE-1:0] H_BASE;

  logic                 MEM_RD;
  logic [ADDR_SIZE-1:0] MEM_ADDR;
  logic [DATA_SIZE-1:0] MEM_RDATA;
  logic                 MEM_WE;
  logic [ADDR_SIZE-1:0] MEM_WADDR;
  logic [DATA_SIZE-1:0] MEM_WDATA;

  logic                 FNN_START;
  logic                 FNN_READY;
  logic                 FNN_W_IN_L_ENABLE;
  logic                 FNN_W_IN_X_ENABLE;
  logic [DATA_SIZE-1:0] FNN_W_IN;
  logic                 FNN_B_IN_ENABLE;
  logic [DATA_SIZE-1:0] FNN_B_IN;
  logic                 FNN_X_IN_ENABLE;
  logic [DATA_SIZE-1:0] FNN_X_IN;
  logic                 FNN_H_OUT_ENABLE;
  logic [DATA_SIZE-1:0] FNN_H_OUT;

  modport master (
    input  SEQ_START, SIZE_X_IN, SIZE_L_IN, W_BASE, B_BASE, X_BASE, H_BASE,
    output SEQ_BUSY, SEQ_READY, SEQ_ERROR,
    output MEM_RD, MEM_ADDR, MEM_WE, MEM_WADDR, MEM_WDATA,
    input  MEM_RDATA,
    output FNN_START, FNN_W_IN_L_ENABLE, FNN_W_IN_X_ENABLE, FNN_W_IN,
    output FNN_B_IN_ENABLE, FNN_B_IN, FNN_X_IN_ENABLE, FNN_X_IN,
    input  FNN_READY, FNN_H_OUT_ENABLE, FNN_H_OUT
  );

  modport slave (
    output SEQ_START, SIZE_X_IN, SIZE_L_IN, W_BASE, B_BASE, X_BASE, H_BASE,
    input  SEQ_BUSY, SEQ_READY, SEQ_ERROR,
    input  MEM_RD, MEM_ADDR, MEM_WE, MEM_WADDR, MEM_WDATA,
    output MEM_RDATA,
    input  FNN_START, FNN_W_IN_L_ENABLE, FNN_W_IN_X_ENABLE, FNN_W_IN,
    input  FNN_B_IN_ENABLE, FNN_B_IN, FNN_X_IN_ENABLE, FNN_X_IN,
    output FNN_READY, FNN_H_OUT_ENABLE, FNN_H_OUT
  );
endinterface

// File: rtl/accelerator_convolutional_fnn_sequencer.sv
// Streams W/B/X from memory into the FNN core, starts it and stores H results.
// Optional WAIT watchdog: define CONVOLUTIONAL_FNN_SEQUENCER_TIMEOUT_EN.
module accelerator_convolutional_fnn_sequencer #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned TIMEOUT   = 4096
) (
  input logic CLK,
  input logic RST,
  accelerator_convolutional_fnn_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StAbort, StLoadW, StLoadB, StLoadX, StFlush, StRun, StWait, StDone
  } state_e;

  typedef enum logic [1:0] {StbNone, StbW, StbB, StbX} stb_e;

  localparam logic [DATA_SIZE-1:0] DOne = DATA_SIZE'(1);
  localparam logic [ADDR_SIZE-1:0] AOne = ADDR_SIZE'(1);

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("TIMEOUT must be nonzero");
  end

  state_e               state_q, state_d;
  stb_e                 stb_q, stb_d;
  logic                 row_first_q, row_first_d;
  logic [DATA_SIZE-1:0] size_x_q, size_x_d, size_l_q, size_l_d;
  logic [ADDR_SIZE-1:0] b_base_q, b_base_d, x_base_q, x_base_d, h_base_q, h_base_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] cnt_q, cnt_d, row_q, row_d, h_cnt_q, h_cnt_d;
  logic                 ovf_q, ovf_d, err_q, err_d;
`ifdef CONVOLUTIONAL_FNN_SEQUENCER_TIMEOUT_EN
  logic [DATA_SIZE-1:0] tmo_q, tmo_d;
`endif

  logic                 mem_rd, mem_we, fnn_start, seq_ready;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [DATA_SIZE-1:0] mem_wdata;

  always_comb begin
    state_d     = state_q;
    stb_d       = StbNone;
    row_first_d = 1'b0;
    size_x_d    = size_x_q;
    size_l_d    = size_l_q;
    b_base_d    = b_base_q;
    x_base_d    = x_base_q;
    h_base_d    = h_base_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    h_cnt_d     = h_cnt_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
`ifdef CONVOLUTIONAL_FNN_SEQUENCER_TIMEOUT_EN
    tmo_d       = '0;
`endif
    mem_rd      = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    fnn_start   = 1'b0;
    seq_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.SEQ_START) begin
          size_x_d = bus.SIZE_X_IN;
          size_l_d = bus.SIZE_L_IN;
          b_base_d = bus.B_BASE;
          x_base_d = bus.X_BASE;
          h_base_d = bus.H_BASE;
          addr_d   = bus.W_BASE;
          cnt_d    = '0;
          row_d    = '0;
          h_cnt_d  = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          if (bus.SIZE_X_IN == '0 || bus.SIZE_L_IN == '0) begin
            err_d   = 1'b1;
            state_d = StAbort;
          end else begin
            state_d = StLoadW;
          end
        end
      end
      StAbort: state_d = StDone;
      // W is row-major and contiguous, so the read address simply increments.
      StLoadW: begin
        mem_rd      = 1'b1;
        stb_d       = StbW;
        row_first_d = (cnt_q == '0);
        addr_d      = addr_q + AOne;
        if (cnt_q == size_x_q - DOne) begin
          cnt_d = '0;
          if (row_q == size_l_q - DOne) begin
            addr_d  = b_base_q;
            state_d = StLoadB;
          end else begin
            row_d = row_q + DOne;
          end
        end else begin
          cnt_d = cnt_q + DOne;
        end
      end
      StLoadB: begin
        mem_rd = 1'b1;
        stb_d  = StbB;
        addr_d = addr_q + AOne;
        cnt_d  = cnt_q + DOne;
        if (cnt_q == size_l_q - DOne) begin
          cnt_d   = '0;
          addr_d  = x_base_q;
          state_d = StLoadX;
        end
      end
      StLoadX: begin
        mem_rd = 1'b1;
        stb_d  = StbX;
        addr_d = addr_q + AOne;
        cnt_d  = cnt_q + DOne;
        if (cnt_q == size_x_q - DOne) begin
          cnt_d   = '0;
          state_d = StFlush;
        end
      end
      // Lets the final X strobe go out before START.
      StFlush: state_d = StRun;
      StRun: begin
        fnn_start = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
`ifdef CONVOLUTIONAL_FNN_SEQUENCER_TIMEOUT_EN
        tmo_d = tmo_q + DOne;
`endif
        if (bus.FNN_H_OUT_ENABLE) begin
          if (h_cnt_q != size_l_q) begin
            mem_we    = 1'b1;
            mem_waddr = h_base_q + ADDR_SIZE'(h_cnt_q);
            mem_wdata = bus.FNN_H_OUT;
            h_cnt_d   = h_cnt_q + DOne;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (bus.FNN_READY) begin
          err_d   = (h_cnt_d != size_l_q) || ovf_d;
          state_d = StDone;
`ifdef CONVOLUTIONAL_FNN_SEQUENCER_TIMEOUT_EN
          tmo_d   = '0;
        end else if (tmo_q == DATA_SIZE'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
          tmo_d   = '0;
`endif
        end
      end
      StDone: begin
        seq_ready = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      stb_q       <= StbNone;
      row_first_q <= 1'b0;
      size_x_q    <= '0;
      size_l_q    <= '0;
      b_base_q    <= '0;
      x_base_q    <= '0;
      h_base_q    <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      h_cnt_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef CONVOLUTIONAL_FNN_SEQUENCER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      row_first_q <= row_first_d;
      size_x_q    <= size_x_d;
      size_l_q    <= size_l_d;
      b_base_q    <= b_base_d;
      x_base_q    <= x_base_d;
      h_base_q    <= h_base_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      h_cnt_q     <= h_cnt_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
`ifdef CONVOLUTIONAL_FNN_SEQUENCER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.SEQ_BUSY  = (state_q inside {StLoadW, StLoadB, StLoadX, StFlush, StRun, StWait});
  assign bus.SEQ_READY = seq_ready;
  assign bus.SEQ_ERROR = seq_ready & err_q;

  assign bus.MEM_RD    = mem_rd;
  assign bus.MEM_ADDR  = mem_rd ? addr_q : '0;
  assign bus.MEM_WE    = mem_we;
  assign bus.MEM_WADDR = mem_waddr;
  assign bus.MEM_WDATA = mem_wdata;

  // Strobes trail the read by one cycle to line up with the memory latency.
  assign bus.FNN_START         = fnn_start;
  assign bus.FNN_W_IN_X_ENABLE = (stb_q == StbW);
  assign bus.FNN_W_IN_L_ENABLE = (stb_q == StbW) && row_first_q;
  assign bus.FNN_W_IN          = (stb_q == StbW) ? bus.MEM_RDATA : '0;
  assign bus.FNN_B_IN_ENABLE   = (stb_q == StbB);
  assign bus.FNN_B_IN          = (stb_q == StbB) ? bus.MEM_RDATA : '0;
  assign bus.FNN_X_IN_ENABLE   = (stb_q == StbX);
  assign bus.FNN_X_IN          = (stb_q == StbX) ? bus.MEM_RDATA : '0;

endmodule
